// File: rtl/alu_seq32.sv
// Sequential 2*W-bit ALU wrapper: runs a double-width operation as two passes
// (low slice, then high slice) through an external combinational W-bit slice ALU.
module alu_seq32 #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    input  logic [3:0]     req_select,
    input  logic           req_mode,
    input  logic           req_carry,
    output logic [W-1:0]   alu_in_a,
    output logic [W-1:0]   alu_in_b,
    output logic [3:0]     alu_select,
    output logic           alu_mode,
    output logic           alu_carry_in,
    input  logic [W-1:0]   alu_out,
    input  logic           alu_carry_out,
    input  logic           alu_compare,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*W-1:0] rsp_result,
    output logic           rsp_carry,
    output logic           rsp_compare,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [2*W-1:0] a_q, a_d;
    logic [2*W-1:0] b_q, b_d;
    logic [3:0]     select_q, select_d;
    logic           mode_q, mode_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   res_lo_q, res_lo_d;
    logic           carry_mid_q, carry_mid_d;
    logic           cmp_lo_q, cmp_lo_d;
    logic [2*W-1:0] result_q, result_d;
    logic           rsp_carry_q, rsp_carry_d;
    logic           rsp_compare_q, rsp_compare_d;

    // The low half is parked in res_lo until the high pass so the visible
    // response only changes in one step at the HI capture.
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        select_d      = select_q;
        mode_d        = mode_q;
        carry_d       = carry_q;
        res_lo_d      = res_lo_q;
        carry_mid_d   = carry_mid_q;
        cmp_lo_d      = cmp_lo_q;
        result_d      = result_q;
        rsp_carry_d   = rsp_carry_q;
        rsp_compare_d = rsp_compare_q;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        alu_in_a      = '0;
        alu_in_b      = '0;
        alu_select    = '0;
        alu_mode      = 1'b0;
        alu_carry_in  = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = rst_n;
                if (req_valid) begin
                    a_d      = req_a;
                    b_d      = req_b;
                    select_d = req_select;
                    mode_d   = req_mode;
                    carry_d  = req_carry;
                    state_d  = LO;
                end
            end
            LO: begin
                alu_in_a     = a_q[W-1:0];
                alu_in_b     = b_q[W-1:0];
                alu_select   = select_q;
                alu_mode     = mode_q;
                alu_carry_in = carry_q;
                res_lo_d     = alu_out;
                carry_mid_d  = alu_carry_out;
                cmp_lo_d     = alu_compare;
                state_d      = HI;
            end
            HI: begin
                alu_in_a      = a_q[2*W-1:W];
                alu_in_b      = b_q[2*W-1:W];
                alu_select    = select_q;
                alu_mode      = mode_q;
                alu_carry_in  = carry_mid_q;
                result_d      = {alu_out, res_lo_q};
                rsp_carry_d   = alu_carry_out;
                rsp_compare_d = cmp_lo_q & alu_compare;
                state_d       = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            select_q      <= '0;
            mode_q        <= 1'b0;
            carry_q       <= 1'b0;
            res_lo_q      <= '0;
            carry_mid_q   <= 1'b0;
            cmp_lo_q      <= 1'b0;
            result_q      <= '0;
            rsp_carry_q   <= 1'b0;
            rsp_compare_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            select_q      <= select_d;
            mode_q        <= mode_d;
            carry_q       <= carry_d;
            res_lo_q      <= res_lo_d;
            carry_mid_q   <= carry_mid_d;
            cmp_lo_q      <= cmp_lo_d;
            result_q      <= result_d;
            rsp_carry_q   <= rsp_carry_d;
            rsp_compare_q <= rsp_compare_d;
        end
    end

    assign rsp_result  = result_q;
    assign rsp_carry   = rsp_carry_q;
    assign rsp_compare = rsp_compare_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq32.sv
// Directed self-checking bench for alu_seq32 with a behavioural 16-bit slice ALU
// (arith = add with carry, logic = bitwise AND, compare = equality).
module tb_alu_seq32;

    localparam int W = 16;

    logic           clk;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [3:0]     req_select;
    logic           req_mode;
    logic           req_carry;
    logic [W-1:0]   alu_in_a;
    logic [W-1:0]   alu_in_b;
    logic [3:0]     alu_select;
    logic           alu_mode;
    logic           alu_carry_in;
    logic [W-1:0]   alu_out;
    logic           alu_carry_out;
    logic           alu_compare;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*W-1:0] rsp_result;
    logic           rsp_carry;
    logic           rsp_compare;
    logic           busy;

    int checks;
    int failures;

    alu_seq32 #(.W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_select   (req_select),
        .req_mode     (req_mode),
        .req_carry    (req_carry),
        .alu_in_a     (alu_in_a),
        .alu_in_b     (alu_in_b),
        .alu_select   (alu_select),
        .alu_mode     (alu_mode),
        .alu_carry_in (alu_carry_in),
        .alu_out      (alu_out),
        .alu_carry_out(alu_carry_out),
        .alu_compare  (alu_compare),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_carry    (rsp_carry),
        .rsp_compare  (rsp_compare),
        .busy         (busy)
    );

    // Behavioural slice ALU
    logic [W:0] slice_sum;
    assign slice_sum     = {1'b0, alu_in_a} + {1'b0, alu_in_b} + {{W{1'b0}}, alu_carry_in};
    assign alu_out       = alu_mode ? (alu_in_a & alu_in_b) : slice_sum[W-1:0];
    assign alu_carry_out = alu_mode ? 1'b0 : slice_sum[W];
    assign alu_compare   = (alu_in_a == alu_in_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one request, keeps req_valid high with junk operands until the
    // response is released, holds rsp_ready low for 'hold' cycles in DONE.
    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] sel, input logic mode, input logic cin,
                                 input int hold, input logic [31:0] exp_res,
                                 input logic exp_carry, input logic exp_cmp);
        int lat;
        bit seen;
        @(negedge clk);
        req_a      = a;
        req_b      = b;
        req_select = sel;
        req_mode   = mode;
        req_carry  = cin;
        req_valid  = 1'b1;
        checkOutput({tag, "_ready_idle"}, {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_a      = ~a;
        req_b      = a;
        req_select = ~sel;
        req_mode   = ~mode;
        req_carry  = ~cin;
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                if (lat == 1) begin
                    checkOutput({tag, "_lo_in_a"}, {48'd0, alu_in_a}, {48'd0, a[15:0]});
                    checkOutput({tag, "_lo_in_b"}, {48'd0, alu_in_b}, {48'd0, b[15:0]});
                    checkOutput({tag, "_lo_ctrl"}, {58'd0, alu_select, alu_mode, alu_carry_in},
                                {58'd0, sel, mode, cin});
                    checkOutput({tag, "_lo_ready"}, {63'd0, req_ready}, 64'd0);
                end
                if (lat == 2) begin
                    checkOutput({tag, "_hi_in_a"}, {48'd0, alu_in_a}, {48'd0, a[31:16]});
                    checkOutput({tag, "_hi_in_b"}, {48'd0, alu_in_b}, {48'd0, b[31:16]});
                    checkOutput({tag, "_hi_sel"}, {60'd0, alu_select}, {60'd0, sel});
                end
                @(posedge clk);
                lat++;
            end
        end
        checkOutput({tag, "_latency"}, seen ? 64'(lat) : 64'd99, 64'd3);
        checkOutput({tag, "_result"}, {32'd0, rsp_result}, {32'd0, exp_res});
        checkOutput({tag, "_carry"}, {63'd0, rsp_carry}, {63'd0, exp_carry});
        checkOutput({tag, "_compare"}, {63'd0, rsp_compare}, {63'd0, exp_cmp});
        checkOutput({tag, "_done_flags"}, {61'd0, busy, req_ready, alu_in_a == 16'd0}, 64'b101);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, "_hold_valid"}, {62'd0, rsp_valid, req_ready}, 64'b10);
            checkOutput({tag, "_hold_result"}, {31'd0, rsp_result, rsp_carry},
                        {31'd0, exp_res, exp_carry});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_idle_flags"}, {61'd0, rsp_valid, busy, req_ready}, 64'b001);
        checkOutput({tag, "_retain"}, {30'd0, rsp_result, rsp_carry, rsp_compare},
                    {30'd0, exp_res, exp_carry, exp_cmp});
    endtask

    initial begin
        int seen_rsp;
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_select = '0;
        req_mode   = 1'b0;
        req_carry  = 1'b0;
        rsp_ready  = 1'b0;
        #1;
        checkOutput("reset_flags", {60'd0, req_ready, rsp_valid, busy, rsp_carry | rsp_compare}, 64'd0);
        checkOutput("reset_result", {32'd0, rsp_result}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");

        applyStimulus("add_lo_carry", 32'h0000FFFF, 32'h00000001, 4'h9, 1'b0, 1'b0, 0,
                      32'h00010000, 1'b0, 1'b0);
        applyStimulus("add_wrap", 32'hFFFFFFFF, 32'h00000001, 4'h9, 1'b0, 1'b0, 0,
                      32'h00000000, 1'b1, 1'b0);
        applyStimulus("add_cin", 32'h00000000, 32'h00000000, 4'h9, 1'b0, 1'b1, 0,
                      32'h00000001, 1'b0, 1'b1);
        applyStimulus("and_mix", 32'hF0F0FFFF, 32'hFF00F00F, 4'hB, 1'b1, 1'b1, 0,
                      32'hF000F00F, 1'b0, 1'b0);
        applyStimulus("and_equal", 32'h12345678, 32'h12345678, 4'hB, 1'b1, 1'b0, 0,
                      32'h12345678, 1'b0, 1'b1);
        applyStimulus("and_hi_diff", 32'h12345678, 32'h00005678, 4'hB, 1'b1, 1'b0, 0,
                      32'h00005678, 1'b0, 1'b0);
        applyStimulus("add_hold", 32'h00001234, 32'h00001111, 4'h9, 1'b0, 1'b0, 5,
                      32'h00002345, 1'b0, 1'b0);

        // Abort an operation mid-flight with an asynchronous reset during HI
        @(negedge clk);
        req_a      = 32'h11112222;
        req_b      = 32'h33334444;
        req_select = 4'h9;
        req_mode   = 1'b0;
        req_carry  = 1'b0;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_in_hi", {47'd0, busy, alu_in_a}, {47'd0, 1'b1, 16'h1111});
        rst_n = 1'b0;
        #1;
        checkOutput("abort_flags", {60'd0, req_ready, rsp_valid, busy, rsp_carry | rsp_compare}, 64'd0);
        checkOutput("abort_result", {32'd0, rsp_result}, 64'd0);
        checkOutput("abort_drive", {28'd0, alu_in_a, alu_in_b, alu_select}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_rsp = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp++;
        end
        checkOutput("abort_no_rsp", 64'(seen_rsp), 64'd0);
        checkOutput("abort_idle_ready", {62'd0, req_ready, busy}, 64'b10);

        applyStimulus("post_abort", 32'h11112222, 32'h33334444, 4'h9, 1'b0, 1'b0, 0,
                      32'h44446666, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
